// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS core: opcodes, field widths, fetch FSM states.
// Build option: IFETCH_HALT_EN adds the HALTED fetch state.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam int OPCODE_W = 6;
  localparam int JIDX_W   = 26;
  localparam int IMM_W    = 16;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD
`ifdef IFETCH_HALT_EN
    , HALTED
`endif
  } fetch_state_t;

  // Sign-extended word offset of a BEQ immediate, already scaled to bytes.
  function automatic logic [31:0] branch_offset(input logic [IMM_W-1:0] imm);
    return {{(32-IMM_W-2){imm[IMM_W-1]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_nextpc.sv
// Next-PC selection for the fetch unit: jump, taken BEQ or sequential.
// Latency: combinational. Backpressure: none.
// Priority: jump over branch; all arithmetic wraps modulo 2^32.
module ifetch_nextpc
  import mips_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [31:0] instr,
  input  logic        branch,
  input  logic        jump,
  input  logic        zero,
  output logic [31:0] next_pc
);

  // The opcode field is decoded by control, not here.
  logic unused_opcode_bits;
  assign unused_opcode_bits = ^instr[31:32-OPCODE_W];

  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = {pc_plus4[31:28], instr[JIDX_W-1:0], 2'b00};
    end else if (branch && zero) begin
      next_pc = pc_plus4 + branch_offset(instr[IMM_W-1:0]);
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: owns the PC, fetches over a ready handshake, holds the instruction register.
// Latency: instr_valid one edge after imem_ready in FETCH; new PC one edge after pcupdate in HOLD.
// Backpressure: imem_rd held with a stable address until imem_ready. Build option: IFETCH_HALT_EN.
module ifetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pcupdate,
  input  logic                branch,
  input  logic                jump,
  input  logic                zero,
  output logic                imem_rd,
  output logic [31:0]         imem_addr,
  input  logic                imem_ready,
  input  logic [31:0]         imem_rdata,
  output logic [31:0]         instr,
  output logic [OPCODE_W-1:0] opcode,
  output logic [31:0]         pc,
  output logic [31:0]         pc_plus4,
  output logic                instr_valid,
  output logic                halted
);

  fetch_state_t state, state_nxt;
  logic [31:0]  next_pc;
  logic         capture;
  logic         advance;

  ifetch_nextpc u_nextpc (
    .pc_plus4 (pc_plus4),
    .instr    (instr),
    .branch   (branch),
    .jump     (jump),
    .zero     (zero),
    .next_pc  (next_pc)
  );

  assign imem_rd   = (state == FETCH);
  assign imem_addr = pc;
  assign opcode    = instr[31:32-OPCODE_W];

`ifdef IFETCH_HALT_EN
  assign halted = (state == HALTED);
`else
  assign halted = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    advance   = 1'b0;
    case (state)
      IDLE: state_nxt = FETCH;
      FETCH: begin
        if (imem_ready) begin
          capture   = 1'b1;
          state_nxt = HOLD;
`ifdef IFETCH_HALT_EN
          if (imem_rdata[31:32-OPCODE_W] == OP_HALT) state_nxt = HALTED;
`endif
        end
      end
      HOLD: begin
        if (pcupdate) begin
          advance   = 1'b1;
          state_nxt = FETCH;
        end
      end
`ifdef IFETCH_HALT_EN
      HALTED: state_nxt = HALTED;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // pc_plus4 is registered alongside pc so both leave the block straight from flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= RESET_PC;
      pc_plus4    <= RESET_PC + 32'd4;
      instr       <= 32'h0;
      instr_valid <= 1'b0;
    end else if (capture) begin
      instr       <= imem_rdata;
      instr_valid <= 1'b1;
    end else if (advance) begin
      pc          <= next_pc;
      pc_plus4    <= next_pc + 32'd4;
      instr_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: scoreboarded fetches plus directed PC-update checks.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        reset, pcupdate, branch, jump, zero, imem_ready;
  logic [31:0] imem_rdata;
  logic        imem_rd;
  logic [31:0] imem_addr, instr, pc, pc_plus4;
  logic [5:0]  opcode;
  logic        instr_valid, halted;

  logic        pcupdate2, imem_ready2;
  logic        imem_rd2;
  logic [31:0] imem_addr2, instr2, pc2, pc_plus42;
  logic [5:0]  opcode2;
  logic        instr_valid2, halted2;

  ifetch_unit #(.RESET_PC(32'h0000_0040)) u_dut (
    .clk(clk), .reset(reset), .pcupdate(pcupdate), .branch(branch), .jump(jump), .zero(zero),
    .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr(instr), .opcode(opcode), .pc(pc), .pc_plus4(pc_plus4),
    .instr_valid(instr_valid), .halted(halted)
  );

  // Second instance starts high in the address space to exercise the J upper-nibble path.
  ifetch_unit #(.RESET_PC(32'h3000_0010)) u_dut_hi (
    .clk(clk), .reset(reset), .pcupdate(pcupdate2), .branch(branch), .jump(jump), .zero(zero),
    .imem_rd(imem_rd2), .imem_addr(imem_addr2), .imem_ready(imem_ready2), .imem_rdata(imem_rdata),
    .instr(instr2), .opcode(opcode2), .pc(pc2), .pc_plus4(pc_plus42),
    .instr_valid(instr_valid2), .halted(halted2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] word;
  } fetch_t;

  fetch_t sb[$];
  fetch_t exp_f;
  logic   prev_valid = 1'b0;

  // Every rising instr_valid must match the oldest fetch the bench answered.
  always @(negedge clk) begin
    if (instr_valid && !prev_valid) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        exp_f = sb.pop_front();
        chk("sb_instr", instr, exp_f.word);
        chk("sb_pc", pc, exp_f.addr);
      end
    end
    prev_valid = instr_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] addr, input logic [31:0] word, input int waits);
    int n = 0;
    while (!imem_rd && n < 20) begin
      tick();
      n++;
    end
    chk("fetch_rd", 32'(imem_rd), 32'd1);
    chk("fetch_addr", imem_addr, addr);
    imem_ready = 1'b0;
    for (int i = 0; i < waits; i++) begin
      tick();
      chk("stall_rd", 32'(imem_rd), 32'd1);
      chk("stall_addr", imem_addr, addr);
      chk("stall_valid", 32'(instr_valid), 32'd0);
    end
    imem_rdata = word;
    imem_ready = 1'b1;
    sb.push_back('{addr, word});
    tick();
    imem_ready = 1'b0;
    chk("fetch_valid", 32'(instr_valid), 32'd1);
  endtask

  task automatic pcu(input logic br, input logic j, input logic z);
    branch   = br;
    jump     = j;
    zero     = z;
    pcupdate = 1'b1;
    tick();
    pcupdate = 1'b0;
    branch   = 1'b0;
    jump     = 1'b0;
    zero     = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset       = 1'b1;
    pcupdate    = 1'b0;
    branch      = 1'b0;
    jump        = 1'b0;
    zero        = 1'b0;
    imem_ready  = 1'b1;
    imem_rdata  = 32'h2008_0005;
    pcupdate2   = 1'b0;
    imem_ready2 = 1'b0;
    repeat (2) tick();

    chk("rst_pc", pc, 32'h40);
    chk("rst_pc4", pc_plus4, 32'h44);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_rd", 32'(imem_rd), 32'd0);
    chk("rst_addr", imem_addr, 32'h40);

    // Release with ready tied high: address on the 2nd cycle, valid on the 3rd.
    reset = 1'b0;
    chk("idle_rd", 32'(imem_rd), 32'd0);
    sb.push_back('{32'h40, 32'h2008_0005});
    tick();
    chk("c2_rd", 32'(imem_rd), 32'd1);
    chk("c2_addr", imem_addr, 32'h40);
    chk("c2_valid", 32'(instr_valid), 32'd0);
    tick();
    chk("c3_valid", 32'(instr_valid), 32'd1);
    chk("c3_opcode", 32'(opcode), 32'(6'b001000));
    chk("c3_rd", 32'(imem_rd), 32'd0);

    imem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("hold_ignores_ready", instr, 32'h2008_0005);
    imem_ready = 1'b0;

    pcu(1'b0, 1'b0, 1'b0);
    chk("seq_pc", pc, 32'h44);
    chk("seq_pc4", pc_plus4, 32'h48);
    chk("seq_rd", 32'(imem_rd), 32'd1);
    chk("seq_valid", 32'(instr_valid), 32'd0);

    fetch(32'h44, 32'h0800_0040, 3);
    pcu(1'b0, 1'b1, 1'b0);
    chk("j_pc", pc, 32'h100);

    fetch(32'h100, 32'h1000_FFFE, 0);
    pcu(1'b1, 1'b0, 1'b1);
    chk("beq_taken_pc", pc, 32'h0FC);

    fetch(32'h0FC, 32'h1000_0000, 1);
    pcu(1'b1, 1'b0, 1'b1);
    chk("beq_zero_off_pc", pc, 32'h100);

    fetch(32'h100, 32'h1000_FFFE, 0);
    pcu(1'b1, 1'b0, 1'b0);
    chk("beq_not_taken_pc", pc, 32'h104);

    // J on the high instance with branch also asserted: jump wins, upper nibble kept.
    chk("hi_rd", 32'(imem_rd2), 32'd1);
    chk("hi_addr", imem_addr2, 32'h3000_0010);
    imem_rdata  = 32'h0800_0040;
    imem_ready2 = 1'b1;
    tick();
    imem_ready2 = 1'b0;
    chk("hi_instr", instr2, 32'h0800_0040);
    branch    = 1'b1;
    jump      = 1'b1;
    zero      = 1'b1;
    pcupdate2 = 1'b1;
    tick();
    pcupdate2 = 1'b0;
    branch    = 1'b0;
    jump      = 1'b0;
    zero      = 1'b0;
    chk("hi_j_pc", pc2, 32'h3000_0100);
    chk("hi_j_rd", 32'(imem_rd2), 32'd1);

    fetch(32'h104, 32'hFC00_0000, 0);
`ifdef IFETCH_HALT_EN
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_valid", 32'(instr_valid), 32'd1);
    pcu(1'b0, 1'b0, 1'b0);
    chk("halt_pc", pc, 32'h104);
    chk("halt_rd", 32'(imem_rd), 32'd0);
    chk("halt_stays", 32'(halted), 32'd1);
`else
    chk("nohalt_flag", 32'(halted), 32'd0);
    pcu(1'b0, 1'b0, 1'b0);
    chk("nohalt_pc", pc, 32'h108);
    chk("nohalt_rd", 32'(imem_rd), 32'd1);
`endif

    // Fresh fetch at RESET_PC, then pcupdate during FETCH and a mid-cycle reset.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("rf_rd", 32'(imem_rd), 32'd1);
    pcu(1'b0, 1'b1, 1'b0);
    chk("fetch_pcu_pc", pc, 32'h40);
    chk("fetch_pcu_rd", 32'(imem_rd), 32'd1);
    tick();
    chk("fetch_pcu_noqueue", pc, 32'h40);
    #2;
    reset      = 1'b1;
    imem_rdata = 32'h1234_5678;
    imem_ready = 1'b1;
    #1;
    chk("async_rd", 32'(imem_rd), 32'd0);
    chk("async_pc", pc, 32'h40);
    tick();
    chk("inflight_instr", instr, 32'h0);
    chk("inflight_valid", 32'(instr_valid), 32'd0);
    imem_ready = 1'b0;
    reset      = 1'b0;
    chk("post_rst_rd", 32'(imem_rd), 32'd0);
    tick();
    chk("post_rst_fetch", 32'(imem_rd), 32'd1);
    chk("post_rst_addr", imem_addr, 32'h40);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch unit for the multicycle MIPS core. It owns the program counter and fetches each instruction from instruction memory over a ready handshake. It holds the instruction in an instruction register and presents its opcode and fields to the control unit. On the control unit's PC-update pulse it selects the next PC (sequential, taken BEQ, or J) and fetches again.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- pcupdate  in  1  one-cycle strobe from control: commit next PC and start a new fetch.
- branch  in  1  control: current instruction is BEQ.
- jump  in  1  control: current instruction is J.
- zero  in  1  ALU zero flag for the current instruction.
- imem_rd  out  1  fetch request; held high until accepted.
- imem_addr  out  32  byte address of the fetch; equals pc.
- imem_ready  in  1  memory accepts the request; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  instruction word.
- instr  out  32  instruction register.
- opcode  out  6  instr[31:26], to control.
- pc  out  32  current PC.
- pc_plus4  out  32  pc + 4.
- instr_valid  out  1  instr holds a fetched instruction for pc.
- halted  out  1  halt opcode reached (see Configuration).

## Operation
- States: IDLE, FETCH, HOLD, HALTED.
- Reset values:
  - state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, halted=0.
  - imem_rd=0, imem_addr=RESET_PC.
- IDLE -> FETCH unconditionally on the first edge after reset deasserts.
- FETCH:
  - imem_rd=1, imem_addr=pc.
  - If imem_ready=1 at an edge: instr<=imem_rdata, instr_valid<=1, go to HOLD.
  - Otherwise remain in FETCH.
- HOLD:
  - imem_rd=0; instr stable.
  - On pcupdate=1: pc<=next_pc, instr_valid<=0, go to FETCH.
- next_pc priority:
  - jump=1: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - else branch=1 and zero=1: pc_plus4 + (sign-extended instr[15:0] << 2).
  - else pc_plus4.
- Arithmetic is 32-bit modulo 2^32. A branch or PC wrap past 32'hFFFF_FFFC wraps silently. next_pc[1:0] is always 00.
- jump and branch both high: jump wins.
- pcupdate in IDLE, FETCH or HALTED: ignored, with no PC change and no queuing.
- imem_ready outside FETCH: ignored.
- Reset mid-fetch: returns to IDLE immediately and drops imem_rd asynchronously. A memory response already in flight is discarded.

## Timing
- Fetch latency: with imem_ready tied high, instr_valid rises 1 cycle after entering FETCH.
- From reset release to the first instr_valid is 2 edges minimum.
- pcupdate sampled in HOLD: the new pc is visible and imem_rd is high on the following cycle.
- Each wait cycle on imem_ready adds exactly one cycle; imem_addr is stable throughout FETCH.
- pc, pc_plus4, opcode and instr are register outputs or direct slices of registers; imem_rd is decoded from the state register only.

## Configuration
- IFETCH_HALT_EN defined:
  - In FETCH, a captured instruction whose opcode is 6'b111111 moves the unit to HALTED instead of HOLD, with instr_valid=1 and halted=1.
  - HALTED is left only by reset.
- IFETCH_HALT_EN undefined:
  - Opcode 6'b111111 is treated like any other instruction (HOLD, waits for pcupdate).
  - halted is tied to 0 and the HALTED state is not compiled in.

## Structure
- Shared package mips_pkg:
  - Opcode constants OP_RTYPE=6'b000000, OP_ADDI=6'b001000, OP_LW=6'b100011, OP_SW=6'b101011, OP_BEQ=6'b000100, OP_J=6'b000010, OP_HALT=6'b111111.
  - Fetch state enum.
  - Instruction field slice widths.
- One sub-module: ifetch_nextpc, purely combinational; takes pc_plus4, instr, branch, jump, zero and returns next_pc.
- The FSM, PC register and instruction register stay in ifetch_unit.

## Test plan
- Reset with RESET_PC=32'h0000_0040 and imem_ready=1, then release → imem_addr=0x40 on the 2nd cycle; instr_valid=1 on the 3rd.
- imem_ready held low for 3 cycles in FETCH → imem_rd high and imem_addr constant for 4 cycles; instr captured only on the ready edge.
- pc=0x100, instr=BEQ with offset 16'hFFFE, branch=1, zero=1, pcupdate → pc=0x0FC. Same case with zero=0 → pc=0x104.
- pc=0x3000_0010, instr=J with target 26'h000_0040, jump=1 and branch=1 → pc=0x3000_0100.
- pcupdate pulsed during FETCH, then reset asserted mid-fetch → pc unchanged by the pulse; after reset, pc=RESET_PC and imem_rd=0 until IDLE exits.
- IFETCH_HALT_EN defined, fetched word 32'hFC00_0000 → halted=1, later pcupdate ignored. Without the macro → HOLD; pcupdate advances pc by 4.
